// File: rtl/pipeline_pkg.sv
// pipeline_pkg: instruction field decoders, opcode/aluop constants and sequencer state encoding
package pipeline_pkg;
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    typedef enum logic {RUN, MD_BUSY} state_t;

    function automatic logic [4:0] f_op(input logic [31:0] i);    return i[31:27]; endfunction
    function automatic logic [4:0] f_rd(input logic [31:0] i);    return i[26:22]; endfunction
    function automatic logic [4:0] f_rs(input logic [31:0] i);    return i[21:17]; endfunction
    function automatic logic [4:0] f_rt(input logic [31:0] i);    return i[16:12]; endfunction
    function automatic logic [4:0] f_aluop(input logic [31:0] i); return i[6:2];   endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and multdiv-in-DX detection
//   fd_insn, dx_insn : instructions in FD and DX registers
//   lu_hazard        : FD reads the register a DX load is about to write
//   dx_is_md         : DX holds a mul or div
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    output logic        lu_hazard,
    output logic        dx_is_md
);
    logic [4:0] dst;
    logic       fd_uses_rt, fd_uses_rd;
    logic       unused_bits;

    assign unused_bits = ^{fd_insn[11:0], dx_insn[21:7], dx_insn[1:0]};
    assign dst         = f_rd(dx_insn);
    assign fd_uses_rt  = f_op(fd_insn) == OP_RTYPE;
    // stores and branches read their second source through the rd field
    assign fd_uses_rd  = f_op(fd_insn) inside {OP_SW, OP_BNE, OP_BLT};
    assign lu_hazard   = f_op(dx_insn) == OP_LW && dst != 5'd0 &&
                         (f_rs(fd_insn) == dst ||
                          (fd_uses_rt && f_rt(fd_insn) == dst) ||
                          (fd_uses_rd && f_rd(fd_insn) == dst));
    assign dx_is_md    = f_op(dx_insn) == OP_RTYPE && f_aluop(dx_insn) inside {ALU_MUL, ALU_DIV};
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the five-stage pipeline with multdiv handshake
//   clk, rst_n          : clock, asynchronous active-low reset
//   fd_insn, dx_insn    : instructions in FD and DX
//   branch_taken        : X-stage taken branch/jump
//   md_ready            : multdiv result valid pulse
//   *_we, *_bubble      : pipeline register write-enables and NOP-load selects
//   md_start, md_busy   : multdiv start pulse, busy indication
//   md_error            : sticky multdiv timeout flag
//   stall_count         : saturating count of cycles with pc_we low
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      fd_insn,
    input  logic [31:0]      dx_insn,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             xm_we,
    output logic             mw_we,
    output logic             fd_bubble,
    output logic             dx_bubble,
    output logic             xm_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_count
);
    localparam int TW = $clog2(MD_TIMEOUT);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          lu_hazard, dx_is_md, err_set;

    hazard_detect u_hd (
        .fd_insn   (fd_insn),
        .dx_insn   (dx_insn),
        .lu_hazard (lu_hazard),
        .dx_is_md  (dx_is_md)
    );

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        dx_we     = 1'b1;
        xm_we     = 1'b1;
        mw_we     = 1'b1;
        fd_bubble = 1'b0;
        dx_bubble = 1'b0;
        xm_bubble = 1'b0;
        md_start  = 1'b0;
        md_busy   = 1'b0;
        err_set   = 1'b0;
        state_n   = state;
        timer_n   = timer;
        if (state == RUN) begin
            if (branch_taken) begin
                fd_bubble = 1'b1;
                dx_bubble = 1'b1;
            end else if (dx_is_md) begin
                md_start  = 1'b1;
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_we     = 1'b0;
                xm_bubble = 1'b1;
                state_n   = MD_BUSY;
                timer_n   = '0;
            end else if (lu_hazard) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_bubble = 1'b1;
            end
        end else begin
            md_busy   = 1'b1;
            xm_bubble = 1'b1;
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_we     = 1'b0;
            if (md_ready) begin
                xm_bubble = 1'b0;
                pc_we     = !lu_hazard;
                fd_we     = !lu_hazard;
                dx_we     = 1'b1;
                dx_bubble = lu_hazard;
                state_n   = RUN;
            end else if (timer == TW'(MD_TIMEOUT - 1)) begin
                // abandon the multdiv: squash it in DX and let the front end advance
                err_set   = 1'b1;
                dx_bubble = 1'b1;
                dx_we     = 1'b1;
                pc_we     = 1'b1;
                fd_we     = 1'b1;
                state_n   = RUN;
            end else begin
                timer_n   = timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            timer       <= '0;
            md_error    <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            md_error <= md_error | err_set;
            if (!pc_we && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed-vector check of stalls, flushes and multdiv sequencing
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fd_insn = NOP, dx_insn = NOP;
    logic        branch_taken = 1'b0, md_ready = 1'b0;
    logic        pc_we, fd_we, dx_we, xm_we, mw_we;
    logic        fd_bubble, dx_bubble, xm_bubble, md_start, md_busy, md_error;
    logic [31:0] stall_count;
    int          n_cmp = 0, n_bad = 0, starts;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .fd_insn(fd_insn), .dx_insn(dx_insn),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
        .fd_bubble(fd_bubble), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
        .md_start(md_start), .md_busy(md_busy), .md_error(md_error),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [4:0] op, rd, rs, rt, alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {pc_we, fd_we, dx_we, xm_we, mw_we}, 5'b11111);
        chk("rst_bub", {fd_bubble, dx_bubble, xm_bubble, md_start, md_busy}, 5'b00000);
        chk("rst_cnt", stall_count, 0);
        chk("rst_err", md_error, 0);
        rst_n = 1'b1;

        // load-use via rs
        dx_insn = ins(OP_LW, 5'd3, 5'd1, 5'd0, 5'd0);
        fd_insn = ins(OP_RTYPE, 5'd5, 5'd3, 5'd4, 5'd0);
        #1 chk("lu_rs", {pc_we, fd_we, dx_we, dx_bubble, fd_bubble}, 5'b00110);
        tick();
        dx_insn = NOP;
        #1 chk("lu_after", {pc_we, fd_we, dx_bubble}, 3'b110);
        chk("lu_cnt", stall_count, 1);
        // load-use via rt of R-type
        dx_insn = ins(OP_LW, 5'd7, 5'd0, 5'd0, 5'd0);
        fd_insn = ins(OP_RTYPE, 5'd1, 5'd2, 5'd7, 5'd0);
        #1 chk("lu_rt", {pc_we, dx_bubble}, 2'b01);
        // sw reads its data register through rd
        fd_insn = ins(OP_SW, 5'd7, 5'd2, 5'd0, 5'd0);
        #1 chk("lu_sw", {pc_we, dx_bubble}, 2'b01);
        // lw in FD does not read rt
        fd_insn = ins(OP_LW, 5'd1, 5'd2, 5'd7, 5'd0);
        #1 chk("lu_lw_rt", {pc_we, dx_bubble}, 2'b10);
        // r0 destination never stalls
        dx_insn = ins(OP_LW, 5'd0, 5'd1, 5'd0, 5'd0);
        fd_insn = NOP;
        #1 chk("lu_r0", {pc_we, fd_we, dx_bubble}, 3'b110);
        tick();
        chk("r0_cnt", stall_count, 1);

        // branch beats load-use
        dx_insn = ins(OP_LW, 5'd3, 5'd1, 5'd0, 5'd0);
        fd_insn = ins(OP_RTYPE, 5'd5, 5'd3, 5'd4, 5'd0);
        branch_taken = 1'b1;
        #1 chk("br_lu", {pc_we, fd_we, fd_bubble, dx_bubble, xm_bubble}, 5'b11110);
        tick();
        branch_taken = 1'b0;
        dx_insn = NOP;
        fd_insn = NOP;
        #1 chk("br_cnt", stall_count, 1);

        // md_ready in RUN is ignored
        md_ready = 1'b1;
        #1 chk("rdy_run", {md_busy, pc_we}, 2'b01);
        tick();
        md_ready = 1'b0;
        #1 chk("rdy_run_st", md_busy, 0);

        // mul with ready on the 17th busy cycle
        starts = 0;
        dx_insn = ins(OP_RTYPE, 5'd4, 5'd1, 5'd2, ALU_MUL);
        #1 chk("mul_start", {md_start, pc_we, fd_we, dx_we, xm_bubble, md_busy}, 6'b100010);
        starts += int'(md_start);
        tick();
        for (int i = 1; i <= 17; i++) begin
            md_ready = (i == 17);
            #1;
            starts += int'(md_start);
            chk($sformatf("mul_busy%0d", i), {md_busy, xm_we, xm_bubble, pc_we, fd_we, dx_we},
                i == 17 ? 6'b110111 : 6'b111000);
            tick();
        end
        md_ready = 1'b0;
        dx_insn = NOP;
        #1 chk("mul_starts", starts, 1);
        chk("mul_done", {md_busy, pc_we}, 2'b01);
        chk("mul_cnt", stall_count, 18);

        // div that never completes
        dx_insn = ins(OP_RTYPE, 5'd4, 5'd1, 5'd2, ALU_DIV);
        #1 chk("div_start", md_start, 1);
        tick();
        for (int i = 1; i <= 40; i++) begin
            #1;
            chk($sformatf("div_busy%0d", i), {md_busy, xm_bubble, dx_bubble, pc_we, fd_we, md_error},
                i == 40 ? 6'b111110 : 6'b110000);
            tick();
        end
        dx_insn = NOP;
        #1 chk("to_err", md_error, 1);
        chk("to_run", md_busy, 0);
        chk("to_cnt", stall_count, 58);
        tick();
        chk("err_sticky", md_error, 1);

        // asynchronous reset while busy
        dx_insn = ins(OP_RTYPE, 5'd4, 5'd1, 5'd2, ALU_MUL);
        tick();
        tick();
        chk("pre_rst_busy", md_busy, 1);
        #2 rst_n = 1'b0;
        #1 chk("arst_busy", md_busy, 0);
        chk("arst_cnt", stall_count, 0);
        chk("arst_err", md_error, 0);
        dx_insn = NOP;
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst", {md_busy, pc_we, md_start}, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the write-enables of the PC, FD, DX, XM and MW pipeline registers and the bubble selects that load a NOP into them. It detects load-use hazards and taken branches, and sequences the multi-cycle multiplier/divider with a start/ready handshake and a timeout watchdog.

## Interface
- MD_TIMEOUT, 40: maximum MD_BUSY cycles before abort
- CNT_W, 32: width of stall counter
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- fd_insn  in  32  instruction held in FD register
- dx_insn  in  32  instruction held in DX register
- branch_taken  in  1  X-stage resolved taken branch/jump this cycle
- md_ready  in  1  multdiv result valid (1-cycle pulse)
- pc_we, fd_we, dx_we, xm_we, mw_we  out  1 each  register write-enables
- fd_bubble, dx_bubble, xm_bubble  out  1 each  load NOP (0x0000_0000) into that register on next edge
- md_start  out  1  1-cycle start pulse to multdiv
- md_busy  out  1  high in MD_BUSY
- md_error  out  1  sticky timeout flag
- stall_count  out  CNT_W  cycles with pc_we=0, saturating

## Operation
- Instruction fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2].
- R-type: opcode 00000. lw: 01000. sw: 00111. bne: 00010. blt: 00110. mul: R-type, aluop 00110. div: R-type, aluop 00111.
- Load-use hazard (LU):
  - Condition: dx is lw, dx.rd≠0, and one of:
    - fd.rs==dx.rd;
    - fd is R-type and fd.rt==dx.rd;
    - fd is sw/bne/blt and fd.rd==dx.rd.
  - Response: pc_we=0, fd_we=0, dx_bubble=1 (dx_we=1).
- Branch flush (BR): branch_taken=1 gives fd_bubble=1 and dx_bubble=1. pc_we stays 1, because the PC loads the target.
- BR has priority over LU.
- States:
  - RUN: normal flow. BR/LU per above, otherwise all we=1 and all bubbles 0.
    - If dx is mul/div and BR=0: md_start=1, pc_we=fd_we=dx_we=0, xm_bubble=1. Next state MD_BUSY, timer cleared.
  - MD_BUSY: pc_we=fd_we=dx_we=0, xm_we=1, xm_bubble=1 every cycle, md_busy=1.
    - If md_ready: xm_bubble=0 (result enters XM), pc_we=fd_we=dx_we=1, LU evaluated normally, next state RUN.
    - Else if timer==MD_TIMEOUT-1: md_error←1, the instruction is dropped (dx_bubble=1, pc_we=fd_we=1), next state RUN.
    - Else timer+1.
- mw_we=1 in every state.
- md_start asserts only on the RUN→MD_BUSY transition, so a mul/div in DX is started exactly once.
- md_ready in RUN is ignored.
- stall_count increments when pc_we=0 and saturates at all-ones.
- md_error clears only on reset.

## Timing
- All we/bubble/md_start outputs are combinational from state, fd_insn, dx_insn, branch_taken and md_ready; they take effect on the same clock edge.
- State, timer, md_error and stall_count are registered.
- Reset (asserted):
  - state=RUN, timer=0, md_error=0, stall_count=0.
  - Outputs follow RUN with the current inputs. With a NOP in FD/DX: all we=1, bubbles=0, md_start=0, md_busy=0.
- LU stall is exactly 1 cycle. The next cycle dx holds a NOP, so LU cannot re-fire.
- mul/div latency: start cycle + N busy cycles. The DX instruction leaves on the md_ready cycle.
- Reset mid-MD_BUSY returns to RUN asynchronously. Any in-flight multdiv result is ignored.
- md_ready and timeout in the same cycle: md_ready wins, md_error unchanged.

## Structure
- Package pipeline_pkg holds:
  - opcode/aluop constants;
  - field-slice functions;
  - state enum {RUN, MD_BUSY};
  - NOP constant.
- One sub-module, hazard_detect: purely combinational, inputs fd_insn and dx_insn, outputs lu_hazard and dx_is_md.
- The FSM, timer and counter live in the top module.

## Test plan
- LU: dx=lw rd=3, fd=add rs=3 → one cycle with pc_we=0, fd_we=0, dx_bubble=1; stall_count=1. Next cycle all we=1.
- LU on r0: dx=lw rd=0, fd rs=0 → no stall.
- Branch with LU: branch_taken=1 while LU is true → fd_bubble=dx_bubble=1, pc_we=1, no stall counted.
- mul: dx=mul, md_ready after 17 cycles:
  - md_start pulses once;
  - md_busy high 17 cycles, with xm_bubble=1 each busy cycle except the ready cycle;
  - stall_count=18; state returns to RUN.
- Timeout: dx=div, md_ready never asserted, MD_TIMEOUT=40 → md_error=1 after 40 busy cycles; dx_bubble=1 on that cycle; state RUN.
- Async reset mid-MD_BUSY (reset low between edges) → md_busy=0 immediately; stall_count=0; md_error=0.
